// File: rtl/clk_div_mc_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// The phase split is kept here so every channel derives H/L identically.
package clk_div_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2,
    ST_BYPASS = 2'd3
  } state_e;

  localparam int unsigned MIN_DIV         = 2;
  localparam int unsigned MAX_RATIO_WIDTH = 16;

  typedef struct packed {
    logic [MAX_RATIO_WIDTH-1:0] high_len;
    logic [MAX_RATIO_WIDTH-1:0] low_len;
  } phase_len_t;

  // Odd ratios put the extra cycle in the low phase.
  function automatic phase_len_t split_ratio(input logic [MAX_RATIO_WIDTH-1:0] ratio);
    phase_len_t p;
    p.high_len = {1'b0, ratio[MAX_RATIO_WIDTH-1:1]};
    p.low_len  = ratio - p.high_len;
    return p;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period FSM, phase counter and glitch-free bypass mux.
// Ratio/enable are only acted upon at a period boundary or from IDLE/BYPASS.
module clk_div_ch
  import clk_div_mc_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH = 8
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   clk_en,
  input  logic [RATIO_WIDTH-1:0] div_ratio,
  output logic                   div_clk,
  output logic                   rise_tick,
  output logic                   active
);

  localparam logic [RATIO_WIDTH-1:0] MIN_DIV_W = RATIO_WIDTH'(MIN_DIV);
  localparam logic [RATIO_WIDTH-1:0] CNT_ZERO  = RATIO_WIDTH'(0);
  localparam logic [RATIO_WIDTH-1:0] CNT_ONE   = RATIO_WIDTH'(1);

  state_e                 state_r, state_s;
  logic [RATIO_WIDTH-1:0] cnt_r, cnt_s;
  logic [RATIO_WIDTH-1:0] ratio_r, ratio_s;
  logic                   tmp_clk_r, tmp_clk_s;
  logic                   tick_r, tick_s;
  logic                   active_r, active_s;
  logic                   bypass_sel_r;
  logic                   ratio_ok_s;
  phase_len_t             phase_s;
  logic [RATIO_WIDTH-1:0] high_len_s, low_len_s;

  assign ratio_ok_s = (div_ratio >= MIN_DIV_W);
  assign phase_s    = split_ratio(MAX_RATIO_WIDTH'(ratio_r));
  assign high_len_s = RATIO_WIDTH'(phase_s.high_len);
  assign low_len_s  = RATIO_WIDTH'(phase_s.low_len);

  // Next-state, counter and output-phase decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    ratio_s   = ratio_r;
    tmp_clk_s = tmp_clk_r;
    tick_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmp_clk_s = 1'b0;
        if (clk_en && ratio_ok_s) begin
          state_s   = ST_HIGH;
          ratio_s   = div_ratio;
          tmp_clk_s = 1'b1;
          cnt_s     = CNT_ONE;
          tick_s    = 1'b1;
        end else if (clk_en) begin
          state_s = ST_BYPASS;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      end
      ST_HIGH: begin
        if (cnt_r == high_len_s) begin
          state_s   = ST_LOW;
          tmp_clk_s = 1'b0;
          cnt_s     = CNT_ONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_LOW: begin
        // cnt==L is the only point where new ratio/enable are honoured.
        if (cnt_r != low_len_s) begin
          cnt_s = cnt_r + CNT_ONE;
        end else if (!clk_en) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (!ratio_ok_s) begin
          state_s = ST_BYPASS;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s   = ST_HIGH;
          ratio_s   = div_ratio;
          tmp_clk_s = 1'b1;
          cnt_s     = CNT_ONE;
          tick_s    = 1'b1;
        end
      end
      ST_BYPASS: begin
        tmp_clk_s = 1'b0;
        if (!clk_en || ratio_ok_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BYPASS;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = CNT_ZERO;
        tmp_clk_s = 1'b0;
      end
    endcase
    active_s = (state_s == ST_HIGH) || (state_s == ST_LOW);
  end

  // Channel state registers.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      ratio_r   <= CNT_ZERO;
      tmp_clk_r <= 1'b0;
      tick_r    <= 1'b0;
      active_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      ratio_r   <= ratio_s;
      tmp_clk_r <= tmp_clk_s;
      tick_r    <= tick_s;
      active_r  <= active_s;
    end
  end

  // Mux select moves only while i_ref_clk is low, and tmp_clk is 0 on both sides of the switch.
  always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bypass_sel_r <= 1'b0;
    end else begin
      bypass_sel_r <= (state_r == ST_BYPASS);
    end
  end

  assign div_clk   = bypass_sel_r ? i_ref_clk : tmp_clk_r;
  assign rise_tick = tick_r;
  assign active    = active_r;

endmodule

// File: rtl/clk_div_mc.sv
// NUM_CH independent integer clock dividers sharing one reference clock.
// Channel c takes its ratio from i_div_ratio[c*RATIO_WIDTH +: RATIO_WIDTH].
module clk_div_mc
  import clk_div_mc_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned RATIO_WIDTH = 8
) (
  input  logic                          i_ref_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_CH-1:0]             i_clk_en,
  input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]             o_div_clk,
  output logic [NUM_CH-1:0]             o_rise_tick,
  output logic [NUM_CH-1:0]             o_active
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(
      .RATIO_WIDTH (RATIO_WIDTH)
    ) u_ch (
      .i_ref_clk (i_ref_clk),
      .i_rst_n   (i_rst_n),
      .clk_en    (i_clk_en[c]),
      .div_ratio (i_div_ratio[c*RATIO_WIDTH +: RATIO_WIDTH]),
      .div_clk   (o_div_clk[c]),
      .rise_tick (o_rise_tick[c]),
      .active    (o_active[c])
    );
  end

endmodule

// File: tb/tb_clk_div_mc.sv
// Scoreboard bench for clk_div_mc: per-channel queues of expected
// {div_clk, tick, active} samples, one per ref cycle, plus a pulse-width monitor.
module tb_clk_div_mc;

  localparam int NUM_CH = 4;
  localparam int RW     = 8;
  localparam real HALF_PERIOD = 5.0;

  typedef struct packed {
    logic div;
    logic tick;
    logic act;
  } exp_t;

  logic                 ref_clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    clk_en;
  logic [NUM_CH*RW-1:0] ratio_bus;
  logic [NUM_CH-1:0]    div_clk;
  logic [NUM_CH-1:0]    rise_tick;
  logic [NUM_CH-1:0]    active;

  int   n_checks;
  int   n_errors;
  exp_t exp_q [NUM_CH][$];
  exp_t mon_e;
  logic glitch_en;
  logic [NUM_CH-1:0] prev_div;
  real  last_t [NUM_CH];

  clk_div_mc #(
    .NUM_CH      (NUM_CH),
    .RATIO_WIDTH (RW)
  ) dut (
    .i_ref_clk   (ref_clk),
    .i_rst_n     (rst_n),
    .i_clk_en    (clk_en),
    .i_div_ratio (ratio_bus),
    .o_div_clk   (div_clk),
    .o_rise_tick (rise_tick),
    .o_active    (active)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push_exp(input int ch, input logic d, input logic t, input logic a);
    exp_t e;
    e.div  = d;
    e.tick = t;
    e.act  = a;
    exp_q[ch].push_back(e);
  endtask

  // One full period: floor(r/2) high cycles, the rest low, tick on the first.
  task automatic push_period(input int ch, input int r);
    for (int i = 0; i < r; i++) push_exp(ch, (i < r / 2), (i == 0), 1'b1);
  endtask

  task automatic push_idle(input int ch, input int n);
    for (int i = 0; i < n; i++) push_exp(ch, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_ratio(input int ch, input int r);
    ratio_bus[ch*RW +: RW] = RW'(r);
  endtask

  function automatic int pending();
    int n = 0;
    for (int c = 0; c < NUM_CH; c++) n += exp_q[c].size();
    return n;
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge ref_clk);
      n++;
    end
    check_val("drain_timeout", pending(), 0);
  endtask

  // Enable, run nper periods of ratio r, drop enable inside the last one.
  task automatic run_simple(input int ch, input int r, input int nper);
    clk_en[ch] = 1'b1;
    set_ratio(ch, r);
    for (int p = 0; p < nper; p++) push_period(ch, r);
    push_idle(ch, 2);
    repeat (nper * r - r + 1) @(negedge ref_clk);
    clk_en[ch] = 1'b0;
    wait_drain(nper * r + 20);
  endtask

  // Scoreboard pop: one expected sample per channel per cycle, just after posedge.
  always @(posedge ref_clk) begin
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (exp_q[c].size() > 0) begin
        mon_e = exp_q[c].pop_front();
        check_val($sformatf("ch%0d div_clk", c), 32'(div_clk[c]), 32'(mon_e.div));
        check_val($sformatf("ch%0d rise_tick", c), 32'(rise_tick[c]), 32'(mon_e.tick));
        check_val($sformatf("ch%0d active", c), 32'(active[c]), 32'(mon_e.act));
      end
    end
  end

  // Pulse-width monitor: no high or low level shorter than half a ref period.
  always @(div_clk or glitch_en) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!glitch_en) begin
        last_t[c] = -1.0;
      end else if (div_clk[c] !== prev_div[c]) begin
        if (last_t[c] >= 0.0)
          check_val($sformatf("ch%0d min_pulse", c),
                    32'((($realtime - last_t[c]) >= HALF_PERIOD) ? 1 : 0), 32'd1);
        last_t[c] = $realtime;
      end
      prev_div[c] = div_clk[c];
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    glitch_en = 1'b0;
    rst_n     = 1'b0;
    clk_en    = '0;
    ratio_bus = '0;

    #2;
    check_val("reset div_clk", 32'(div_clk), 32'd0);
    check_val("reset rise_tick", 32'(rise_tick), 32'd0);
    check_val("reset active", 32'(active), 32'd0);
    repeat (2) @(negedge ref_clk);
    rst_n = 1'b1;
    glitch_en = 1'b1;
    for (int c = 0; c < NUM_CH; c++) push_idle(c, 2);
    wait_drain(10);

    run_simple(0, 4, 3);
    run_simple(1, 5, 3);
    run_simple(0, 2, 4);
    run_simple(1, 255, 1);

    // Ratio change during the high phase: current period keeps ratio 4.
    clk_en[0] = 1'b1;
    set_ratio(0, 4);
    push_period(0, 4);
    push_period(0, 6);
    push_period(0, 6);
    push_idle(0, 2);
    @(negedge ref_clk);
    set_ratio(0, 6);
    repeat (10) @(negedge ref_clk);
    clk_en[0] = 1'b0;
    wait_drain(40);

    // Enable dropped on the first high cycle: period of 8 still completes.
    run_simple(2, 8, 1);

    // Bypass entry, bypass exit to divide-by-3.
    clk_en[3] = 1'b1;
    set_ratio(3, 1);
    push_idle(3, 1);
    for (int i = 0; i < 5; i++) push_exp(3, 1'b1, 1'b0, 1'b0);
    push_period(3, 3);
    push_period(3, 3);
    push_idle(3, 2);
    repeat (5) @(negedge ref_clk);
    set_ratio(3, 3);
    repeat (5) @(negedge ref_clk);
    clk_en[3] = 1'b0;
    wait_drain(30);

    // All channels running, reset pulsed mid-period.
    for (int c = 0; c < NUM_CH; c++) begin
      clk_en[c] = 1'b1;
      set_ratio(c, 4 + c);
      push_period(c, 4 + c);
    end
    repeat (3) @(negedge ref_clk);
    #2;
    glitch_en = 1'b0;
    rst_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    #1;
    check_val("async reset div_clk", 32'(div_clk), 32'd0);
    check_val("async reset rise_tick", 32'(rise_tick), 32'd0);
    check_val("async reset active", 32'(active), 32'd0);
    repeat (2) @(negedge ref_clk);
    rst_n = 1'b1;
    glitch_en = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      push_period(c, 4 + c);
      push_idle(c, 2);
    end
    @(negedge ref_clk);
    clk_en = '0;
    wait_drain(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_div_mc.md
Name: clk_div_mc

Overview:
- Multi-channel, parametrised successor to the single-output integer clock divider.
- Generates NUM_CH divided clocks from one reference clock. Each channel has its own enable and ratio.
- Ratio and enable changes take effect only at period boundaries, so there are no runt pulses.
- Adds a bypass path that is switched glitch-free, plus a per-channel rising-edge tick for the control logic in the reference domain.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16)
- RATIO_WIDTH, 8, width of each channel's divide ratio (ratio range 2..2^RATIO_WIDTH-1)

Ports:
- i_ref_clk  in  1  reference clock, the only clock
- i_rst_n  in  1  asynchronous active-low reset
- i_clk_en  in  NUM_CH  per-channel enable
- i_div_ratio  in  NUM_CH*RATIO_WIDTH  packed ratios; channel c occupies bits [c*RATIO_WIDTH +: RATIO_WIDTH]
- o_div_clk  out  NUM_CH  divided (or bypassed) clocks
- o_rise_tick  out  NUM_CH  1-cycle pulse, in the i_ref_clk domain, on the edge where o_div_clk rises (divide mode only)
- o_active  out  NUM_CH  channel is in divide mode (state HIGH or LOW)

Behaviour:
- Clock and reset: one clock, i_ref_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: state=IDLE, counter=0, tmp_clk=0, bypass_sel=0, o_div_clk=0, o_rise_tick=0, o_active=0.
- Per-channel FSM states: IDLE, HIGH, LOW, BYPASS. All transitions occur on posedge i_ref_clk.
- Active ratio R is latched only on entry to HIGH. Phase lengths: H=floor(R/2), L=R-H. For odd R, the low phase is the longer one.
- IDLE:
  - en && ratio>=2 -> HIGH; latch R; tmp_clk=1; cnt=1; pulse tick.
  - en && ratio<2 -> BYPASS.
  - Otherwise stay in IDLE.
- HIGH:
  - cnt==H -> LOW; tmp_clk=0; cnt=1.
  - Otherwise cnt+1.
- LOW (cnt==L is the period boundary; inputs are sampled there):
  - !en -> IDLE.
  - ratio<2 -> BYPASS.
  - Otherwise -> HIGH; latch new R; tmp_clk=1; cnt=1; pulse tick.
  - cnt<L: cnt+1.
- BYPASS: !en or ratio>=2 -> IDLE. IDLE then re-evaluates on the next edge, so there is exactly one idle cycle between modes.
- Counter width is RATIO_WIDTH. It never exceeds L, so it cannot wrap.
- Changes to ratio or enable during HIGH, or during LOW before the boundary, are ignored; the current period always completes. Disable parks o_div_clk low.
- Output stage:
  - bypass_sel = (state==BYPASS), registered on negedge i_ref_clk, async reset to 0.
  - o_div_clk = bypass_sel ? i_ref_clk : tmp_clk.
  - bypass_sel changes only while i_ref_clk is low, and tmp_clk is 0 in BYPASS and IDLE, so the switch is glitch-free in both directions.
- Latency: enable sampled high in IDLE at edge k -> o_div_clk high after edge k. tmp_clk is driven directly from a flop.
- o_active = state is HIGH or LOW (registered decode).
- o_rise_tick is a registered pulse, high for the one cycle following the entering edge.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset asserted mid-period: all channels return to reset values immediately, and o_div_clk goes low asynchronously.

Decomposition:
- Package clk_div_mc_pkg:
  - state enum (IDLE, HIGH, LOW, BYPASS, 2 bits)
  - localparam MIN_DIV=2
  - function computing H and L from R
- Sub-module clk_div_ch: a single channel (FSM, counter, negedge bypass_sel, output mux).
- Top level instantiates NUM_CH copies via generate and slices the packed ratio bus.

Test Plan:
- Reset, then ch0 en=1, ratio=4 -> o_div_clk pattern 1,1,0,0 repeating; tick every 4 cycles; o_active=1.
- ch1 ratio=5 -> high 2, low 3 per period. Ratio=2 -> toggles every cycle. Ratio=255 -> high 127, low 128.
- ch0 ratio changed 4->6 during the high phase -> current period stays 4 cycles; next period high 3/low 3; first tick of the new period exactly at the boundary.
- ch2 en dropped mid-high with ratio=8 -> period completes (4 high, 4 low), then o_div_clk stays 0, o_active=0, no further ticks.
- ch3 ratio=1, en=1 -> after one IDLE cycle o_div_clk follows i_ref_clk from the next falling edge with no partial pulse. Ratio->3 -> bypass ends cleanly at a falling edge, one idle cycle, then divide-by-3. Checked with a glitch monitor (minimum pulse width >= half a ref period).
- All 4 channels running with different ratios, i_rst_n pulsed low mid-period -> all outputs 0 asynchronously. After release, each channel restarts from IDLE with its first rising edge on the first sampled edge.
